reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 122 ++++++++++++
 tb/tb_reorder_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit ROB with CDB writeback and mispredict flush.
// Define ROB_CDB_BYPASS_EN to forward a same-cycle CDB write onto the query ports.
module reorder_buffer #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 IS_sgn,
   input  logic [4:0]           IS_rd,
   output logic [ROB_WIDTH-1:0] IS_name,
   output logic                 IS_full,
   input  logic [ROB_WIDTH-1:0] ROB_ord1,
   input  logic [ROB_WIDTH-1:0] ROB_ord2,
   output logic                 ROB_rdy1,
   output logic                 ROB_rdy2,
   output logic [31:0]          ROB_val1,
   output logic [31:0]          ROB_val2,
   input  logic                 CDB_sgn,
   input  logic [ROB_WIDTH-1:0] CDB_name,
   input  logic [31:0]          CDB_value,
   input  logic                 CDB_mispred,
   input  logic [31:0]          CDB_target,
   output logic                 commit_sgn,
   output logic [4:0]           commit_dest,
   output logic [31:0]          commit_value,
   output logic [ROB_WIDTH-1:0] commit_name,
   output logic                 flush,
   output logic [31:0]          flush_pc
);
   localparam int DEPTH = 2 ** ROB_WIDTH;
   logic [DEPTH-1:0]     busy, ready, mispred;
   logic [4:0]           dest   [DEPTH];
   logic [31:0]          value  [DEPTH];
   logic [31:0]          target [DEPTH];
   logic [ROB_WIDTH-1:0] head, tail;
   logic [ROB_WIDTH:0]   count, count_nxt;
   logic                 do_issue, do_cdb, do_commit, do_flush, byp1, byp2;

   // count never exceeds DEPTH, so its top bit alone marks a full buffer
   assign IS_full   = count[ROB_WIDTH];
   assign IS_name   = tail;
   assign do_commit = (count != '0) && ready[head];
   assign do_flush  = do_commit && mispred[head];
   assign do_issue  = IS_sgn && !IS_full;
   assign do_cdb    = CDB_sgn && busy[CDB_name];

   always_comb begin
`ifdef ROB_CDB_BYPASS_EN
      byp1 = do_cdb && (CDB_name == ROB_ord1);
      byp2 = do_cdb && (CDB_name == ROB_ord2);
`else
      byp1 = 1'b0;
      byp2 = 1'b0;
`endif
      ROB_rdy1  = byp1 || (busy[ROB_ord1] && ready[ROB_ord1]);
      ROB_rdy2  = byp2 || (busy[ROB_ord2] && ready[ROB_ord2]);
      ROB_val1  = byp1 ? CDB_value : value[ROB_ord1];
      ROB_val2  = byp2 ? CDB_value : value[ROB_ord2];
      count_nxt = count + (ROB_WIDTH+1)'(do_issue) - (ROB_WIDTH+1)'(do_commit);
   end

   // payload arrays carry no reset; busy/ready gate every use of them
   always_ff @(posedge clk) begin
      if (!rst && rdy && !do_flush) begin
         if (do_cdb) begin
            value[CDB_name]  <= CDB_value;
            target[CDB_name] <= CDB_target;
         end
         if (do_issue) dest[tail] <= IS_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         busy         <= '0;
         ready        <= '0;
         mispred      <= '0;
         commit_sgn   <= 1'b0;
         commit_dest  <= '0;
         commit_value <= '0;
         commit_name  <= '0;
         flush        <= 1'b0;
         flush_pc     <= '0;
      end else begin
         commit_sgn <= rdy && do_commit;
         flush      <= rdy && do_flush;
         if (rdy && do_commit) begin
            commit_dest  <= dest[head];
            commit_value <= value[head];
            commit_name  <= head;
         end
         if (rdy && do_flush) begin
            flush_pc <= target[head];
            busy     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
         end else if (rdy) begin
            if (do_cdb) begin
               ready[CDB_name]   <= 1'b1;
               mispred[CDB_name] <= CDB_mispred;
            end
            // issue follows the CDB write so it wins on a shared index
            if (do_issue) begin
               busy[tail]    <= 1'b1;
               ready[tail]   <= 1'b0;
               mispred[tail] <= 1'b0;
               tail          <= tail + ROB_WIDTH'(1);
            end
            if (do_commit) begin
               busy[head] <= 1'b0;
               head       <= head + ROB_WIDTH'(1);
            end
            count <= count_nxt;
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic against a queue-based ROB model.
module tb_reorder_buffer;
   localparam int W = 4;
   localparam int DEPTH = 16;

   logic clk, rst, rdy, IS_sgn, IS_full, ROB_rdy1, ROB_rdy2, CDB_sgn, CDB_mispred;
   logic commit_sgn, flush;
   logic [4:0] IS_rd, commit_dest;
   logic [W-1:0] IS_name, ROB_ord1, ROB_ord2, CDB_name, commit_name;
   logic [31:0] ROB_val1, ROB_val2, CDB_value, CDB_target, commit_value, flush_pc;

   int checks = 0;
   int errors = 0;

   bit        m_busy [DEPTH];
   bit        m_ready[DEPTH];
   bit        m_mis  [DEPTH];
   bit [4:0]  m_dest [DEPTH];
   bit [31:0] m_val  [DEPTH];
   bit [31:0] m_tgt  [DEPTH];
   int        q[$];
   int        nxt;
   bit        e_csgn, e_flush;
   bit [4:0]  e_cdest;
   bit [31:0] e_cval, e_fpc;
   int        e_cname;

   reorder_buffer #(.ROB_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .IS_sgn(IS_sgn), .IS_rd(IS_rd),
      .IS_name(IS_name), .IS_full(IS_full), .ROB_ord1(ROB_ord1), .ROB_ord2(ROB_ord2),
      .ROB_rdy1(ROB_rdy1), .ROB_rdy2(ROB_rdy2), .ROB_val1(ROB_val1), .ROB_val2(ROB_val2),
      .CDB_sgn(CDB_sgn), .CDB_name(CDB_name), .CDB_value(CDB_value),
      .CDB_mispred(CDB_mispred), .CDB_target(CDB_target), .commit_sgn(commit_sgn),
      .commit_dest(commit_dest), .commit_value(commit_value), .commit_name(commit_name),
      .flush(flush), .flush_pc(flush_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit byp(input int o);
`ifdef ROB_CDB_BYPASS_EN
      return CDB_sgn && (int'(CDB_name) == o) && m_busy[o];
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit exp_rdy(input int o);
      return byp(o) || (m_busy[o] && m_ready[o]);
   endfunction

   function automatic bit [31:0] exp_val(input int o);
      return byp(o) ? CDB_value : m_val[o];
   endfunction

   task automatic model_edge();
      bit commit;
      int h;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = 0; m_ready[i] = 0; m_mis[i] = 0;
         end
         q.delete();
         nxt = 0;
         e_csgn = 0; e_flush = 0; e_cdest = 0; e_cval = 0; e_cname = 0; e_fpc = 0;
         return;
      end
      e_csgn = 0;
      e_flush = 0;
      if (!rdy) return;
      commit = q.size() > 0 && m_ready[q[0]];
      h = commit ? q[0] : 0;
      if (commit) begin
         e_csgn = 1; e_flush = m_mis[h];
         e_cdest = m_dest[h]; e_cval = m_val[h]; e_cname = h;
      end
      if (e_flush) begin
         e_fpc = m_tgt[h];
         for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
         q.delete();
         nxt = 0;
         return;
      end
      if (CDB_sgn && m_busy[CDB_name]) begin
         m_val[CDB_name] = CDB_value; m_tgt[CDB_name] = CDB_target;
         m_mis[CDB_name] = CDB_mispred; m_ready[CDB_name] = 1;
      end
      if (IS_sgn && q.size() < DEPTH) begin
         m_busy[nxt] = 1; m_ready[nxt] = 0; m_mis[nxt] = 0; m_dest[nxt] = IS_rd;
         q.push_back(nxt);
         nxt = (nxt + 1) % DEPTH;
      end
      if (commit) begin
         m_busy[h] = 0;
         void'(q.pop_front());
      end
   endtask

   task automatic check_comb();
      bit r1, r2;
      r1 = exp_rdy(int'(ROB_ord1));
      r2 = exp_rdy(int'(ROB_ord2));
      check("is_full", IS_full, q.size() == DEPTH);
      check("is_name", IS_name, nxt);
      check("rob_rdy1", ROB_rdy1, r1);
      check("rob_rdy2", ROB_rdy2, r2);
      if (r1) check("rob_val1", ROB_val1, exp_val(int'(ROB_ord1)));
      if (r2) check("rob_val2", ROB_val2, exp_val(int'(ROB_ord2)));
   endtask

   task automatic check_regs();
      check("commit_sgn", commit_sgn, e_csgn);
      check("flush", flush, e_flush);
      check("commit_dest", commit_dest, e_cdest);
      check("commit_value", commit_value, e_cval);
      check("commit_name", commit_name, e_cname);
      check("flush_pc", flush_pc, e_fpc);
   endtask

   task automatic step();
      #1;
      check_comb();
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic do_reset();
      rst = 1; IS_sgn = 0; CDB_sgn = 0; CDB_mispred = 0; rdy = 1;
      step();
      rst = 0;
   endtask

   task automatic issue(input logic [4:0] rd);
      IS_sgn = 1; IS_rd = rd;
      step();
      IS_sgn = 0;
   endtask

   task automatic cdb(input int name, input logic [31:0] val, input logic mis, input logic [31:0] tgt);
      CDB_sgn = 1; CDB_name = W'(name); CDB_value = val; CDB_mispred = mis; CDB_target = tgt;
      step();
      CDB_sgn = 0; CDB_mispred = 0;
   endtask

   initial begin
      rst = 1; rdy = 1; IS_sgn = 0; IS_rd = 0; ROB_ord1 = 0; ROB_ord2 = 0;
      CDB_sgn = 0; CDB_name = 0; CDB_value = 0; CDB_mispred = 0; CDB_target = 0;
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
      check("rst_full", IS_full, 0);
      check("rst_name", IS_name, 0);
      check("rst_rdy1", ROB_rdy1, 0);
      check("rst_rdy2", ROB_rdy2, 0);
      rst = 0;

      // single issue then writeback of the head
      do_reset();
      issue(5);
      cdb(0, 32'h1234, 0, 0);
      check("lat_early", commit_sgn, 0);
      step();
      check("c1_sgn", commit_sgn, 1);
      check("c1_dest", commit_dest, 5);
      check("c1_val", commit_value, 32'h1234);
      check("c1_name", commit_name, 0);
      step();
      check("c1_pulse", commit_sgn, 0);

      // fill, overfill, then reuse tag 0
      do_reset();
      for (int i = 0; i < DEPTH; i++) issue(5'(i + 1));
      check("fill_full", IS_full, 1);
      check("fill_name", IS_name, 0);
      issue(7);
      check("over_full", IS_full, 1);
      check("over_name", IS_name, 0);
      cdb(0, 32'hCAFE, 0, 0);
      IS_sgn = 1; IS_rd = 9;
      step();
      IS_sgn = 0;
      check("full_commit", commit_sgn, 1);
      check("full_drop_iss", IS_full, 0);
      check("full_drop_name", IS_name, 0);
      issue(9);
      check("reuse_full", IS_full, 1);
      check("reuse_name", IS_name, 1);

      // out-of-order writeback, in-order commit
      do_reset();
      for (int i = 0; i < 3; i++) issue(5'(i + 10));
      cdb(2, 32'h22, 0, 0);
      check("ooo_c2", commit_sgn, 0);
      cdb(1, 32'h11, 0, 0);
      check("ooo_c1", commit_sgn, 0);
      cdb(0, 32'h00, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("ooo_sgn", commit_sgn, 1);
         check("ooo_name", commit_name, i);
         check("ooo_dest", commit_dest, i + 10);
      end
      step();
      check("ooo_end", commit_sgn, 0);

      // mispredicted head flushes everything
      do_reset();
      for (int i = 0; i < 3; i++) issue(5'(i + 1));
      cdb(0, 32'h55, 1, 32'h100);
      step();
      check("mp_sgn", commit_sgn, 1);
      check("mp_flush", flush, 1);
      check("mp_pc", flush_pc, 32'h100);
      check("mp_name", IS_name, 0);
      check("mp_full", IS_full, 0);
      ROB_ord1 = 1;
      cdb(1, 32'h66, 0, 0);
      check("mp_flush_pulse", flush, 0);
      check("mp_late_rdy", ROB_rdy1, 0);
      step();
      check("mp_no_commit", commit_sgn, 0);

      // query of tag 3 with a same-cycle CDB write
      do_reset();
      for (int i = 0; i < 4; i++) issue(5'(i + 1));
      ROB_ord1 = 3;
      CDB_sgn = 1; CDB_name = 3; CDB_value = 32'hABCD; CDB_mispred = 0;
      #1;
`ifdef ROB_CDB_BYPASS_EN
      check("byp_rdy", ROB_rdy1, 1);
      check("byp_val", ROB_val1, 32'hABCD);
`else
      check("byp_rdy", ROB_rdy1, 0);
`endif
      step();
      CDB_sgn = 0;
      #1;
      check("byp_next_rdy", ROB_rdy1, 1);
      check("byp_next_val", ROB_val1, 32'hABCD);

      // rdy low freezes a ready head
      do_reset();
      issue(3);
      cdb(0, 32'h77, 0, 0);
      rdy = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_sgn", commit_sgn, 0);
         check("hold_name", IS_name, 1);
      end
      rdy = 1;
      step();
      check("hold_release", commit_sgn, 1);
      check("hold_val", commit_value, 32'h77);

      // random traffic
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom % 250) == 0;
         rdy = ($urandom % 8) != 0;
         IS_sgn = 1'($urandom);
         IS_rd = 5'($urandom);
         CDB_sgn = 1'($urandom);
         CDB_name = (q.size() > 0 && ($urandom % 4) != 0)
                    ? W'(q[$urandom_range(q.size() - 1, 0)]) : W'($urandom);
         CDB_value = $urandom;
         CDB_mispred = ($urandom % 24) == 0;
         CDB_target = $urandom;
         ROB_ord1 = W'($urandom);
         ROB_ord2 = (q.size() > 0) ? W'(q[0]) : W'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
